// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, HI/LO
// direct-write codes and the busy counter width.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5,
        MD_MSUB  = 3'd6,
        MD_MSUBU = 3'd7
    } md_op_e;

    localparam logic [1:0] HILO_NONE = 2'd0;
    localparam logic [1:0] HILO_MTHI = 2'd1;
    localparam logic [1:0] HILO_MTLO = 2'd2;

    // Cycle parameters are limited to 1..31, so five bits cover the counter.
    localparam int CNT_W = 5;

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational {hi,lo} result for every multiply/divide op; wr is low when
// the op must leave HI/LO untouched (division by zero).
module md_calc
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e             op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result,
    output logic               wr
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0]      w_prod_s;
    logic [2*WIDTH-1:0]      w_prod_u;
    logic [2*WIDTH-1:0]      w_acc;
    logic                    w_b_zero;
    logic                    w_ovf;
    logic [WIDTH-1:0]        w_udiv_b;
    logic [WIDTH-1:0]        w_uq;
    logic [WIDTH-1:0]        w_ur;
    logic signed [WIDTH-1:0] w_sa;
    logic signed [WIDTH-1:0] w_sb;
    logic signed [WIDTH-1:0] w_sq;
    logic signed [WIDTH-1:0] w_sr;

    assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_acc    = {hi, lo};

    // Divisors are forced to 1 on the special cases so the dividers never see
    // an undefined operation; the real answer is substituted below.
    assign w_b_zero = (b == '0);
    assign w_ovf    = (a == MIN_INT) && (b == '1);
    assign w_udiv_b = w_b_zero ? WIDTH'(1) : b;
    assign w_sa     = $signed(a);
    assign w_sb     = (w_b_zero || w_ovf) ? WIDTH'(1) : $signed(b);
    assign w_sq     = w_sa / w_sb;
    assign w_sr     = w_sa % w_sb;
    assign w_uq     = a / w_udiv_b;
    assign w_ur     = a % w_udiv_b;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result = '0;
        wr     = 1'b1;
        case (op)
            MD_MULT:  result = w_prod_s;
            MD_MULTU: result = w_prod_u;
            MD_MADD:  result = w_acc + w_prod_s;
            MD_MADDU: result = w_acc + w_prod_u;
            MD_MSUB:  result = w_acc - w_prod_s;
            MD_MSUBU: result = w_acc - w_prod_u;
            MD_DIV: begin
                wr     = !w_b_zero;
                result = w_ovf ? {{WIDTH{1'b0}}, MIN_INT} : {w_sr, w_sq};
            end
            MD_DIVU: begin
                wr     = !w_b_zero;
                result = {w_ur, w_uq};
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: the result is computed at
// launch, held in pending registers, and committed when the counter expires.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_pend_hi;
    logic [WIDTH-1:0]   r_pend_lo;
    logic               r_pend_wr;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] w_result;
    logic               w_wr;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (r_hi),
        .lo     (r_lo),
        .result (w_result),
        .wr     (w_wr)
    );

    assign busy      = (r_cnt != '0);
    assign stall_req = busy | start;
    assign hi        = r_hi;
    assign lo        = r_lo;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the pending registers are reset too, so a flushed operation can never leak a stale result.
        if (!reset) begin
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (cancel) begin
            r_cnt     <= '0;
            r_pend_wr <= 1'b0;
        end else if (busy) begin
            // NOTE: non-blocking updates let r_cnt and the commit both read the pre-edge counter.
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1) && r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (start) begin
            {r_pend_hi, r_pend_lo} <= w_result;
            r_pend_wr <= w_wr;
            r_cnt     <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (hilo_we == HILO_MTHI) begin
            r_hi <= wdata;
        end else if (hilo_we == HILO_MTLO) begin
            r_lo <= wdata;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a vector table run through a scoreboard
// queue, plus hand sequences for cancel, reset, hazards and 1-cycle timing.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  hilo_we;
    logic [31:0] wdata;
    logic        cancel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        f_start;
    logic [1:0]  f_hilo_we;
    logic        f_cancel;
    logic        f_busy;
    logic        f_stall;
    logic [31:0] f_hi;
    logic [31:0] f_lo;

    int n_checks = 0;
    int n_err    = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [63:0] exp;
        int          cycles;
        string       name;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    md_unit u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hilo_we(hilo_we), .wdata(wdata), .cancel(cancel), .busy(busy),
        .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_fast (
        .clk(clk), .reset(reset), .start(f_start), .op(op), .a(a), .b(b),
        .hilo_we(f_hilo_we), .wdata(wdata), .cancel(f_cancel), .busy(f_busy),
        .stall_req(f_stall), .hi(f_hi), .lo(f_lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] sel, input logic [31:0] data);
        hilo_we = sel;
        wdata   = data;
        step();
        hilo_we = HILO_NONE;
    endtask

    task automatic run_op(input md_op_e o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [63:0] exp, input int exp_cyc, input string name);
        int n;
        logic [63:0] e;
        op = o; a = va; b = vb; start = 1'b1;
        sb_q.push_back(exp);
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 64) begin
            n++;
            step();
        end
        check({name, " cycles"}, 64'(n), 64'(exp_cyc));
        e = sb_q.pop_front();
        check({name, " hilo"}, {hi, lo}, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] e;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'h0, 32'h0,        64'hFFFFFFFF_FFFFFFFA, 5,  "mult_neg"};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h0, 32'h0,        64'h00000002_FFFFFFFA, 5,  "multu"};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0, 32'h0,        64'hFFFFFFFF_FFFFFFFD, 10, "div_neg7_2"};
        vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5,        64'h00000000_80000000, 10, "div_ovf"};
        vecs[4]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h0, 32'h0,        64'h00000001_FFFFFFFD, 10, "div_7_neg2"};
        vecs[5]  = '{MD_DIVU,  32'd7,        32'd2,        32'h0, 32'h0,        64'h00000001_00000003, 10, "divu_7_2"};
        vecs[6]  = '{MD_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,        64'h80000000_00000000, 10, "divu_big"};
        vecs[7]  = '{MD_MADD,  32'd3,        32'd4,        32'h0, 32'd10,       64'h00000000_00000016, 5,  "madd"};
        vecs[8]  = '{MD_MSUB,  32'd2,        32'd11,       32'h0, 32'd22,       64'h00000000_00000000, 5,  "msub"};
        vecs[9]  = '{MD_MADDU, 32'd1,        32'd1,        32'h0, 32'hFFFFFFFF, 64'h00000001_00000000, 5,  "maddu_carry"};
        vecs[10] = '{MD_MSUBU, 32'd1,        32'd1,        32'h0, 32'h0,        64'hFFFFFFFF_FFFFFFFF, 5,  "msubu_wrap"};
        vecs[11] = '{MD_DIVU,  32'd5,        32'd0,        32'h0, 32'h1234,     64'h00000000_00001234, 10, "divu_by0"};
        vecs[12] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0,        64'h40000000_00000000, 5,  "mult_minmin"};
        vecs[13] = '{MD_MADD,  32'hFFFFFFFF, 32'd5,        32'h0, 32'd10,       64'h00000000_00000005, 5,  "madd_neg"};
        vecs[14] = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0, 32'h0,        64'hFFFFFFFF_00000003, 10, "div_negneg"};

        reset = 1'b0; start = 1'b0; op = MD_MULT; a = '0; b = '0;
        hilo_we = HILO_NONE; wdata = '0; cancel = 1'b0;
        f_start = 1'b0; f_hilo_we = HILO_NONE; f_cancel = 1'b0;

        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        start = 1'b1;
        #1;
        check("reset stall follows start", 64'(stall_req), 64'd1);
        start = 1'b0;
        #1;
        check("reset stall idle", 64'(stall_req), 64'd0);
        #10 reset = 1'b1;

        // First edge after release accepts a direct write.
        do_write(HILO_MTLO, 32'hCAFE);
        check("first edge mtlo", {hi, lo}, 64'h00000000_0000CAFE);

        for (int i = 0; i < NV; i++) begin
            do_write(HILO_MTHI, vecs[i].pre_hi);
            do_write(HILO_MTLO, vecs[i].pre_lo);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].cycles, vecs[i].name);
        end

        // divu by zero with a start and an mtlo injected mid-busy.
        do_write(HILO_MTHI, 32'h0);
        do_write(HILO_MTLO, 32'h1234);
        op = MD_DIVU; a = 32'd5; b = 32'd0; start = 1'b1;
        sb_q.push_back(64'h00000000_00001234);
        step();
        op = MD_MULT; a = 32'd3; b = 32'd3; start = 1'b1;
        hilo_we = HILO_MTLO; wdata = 32'hDEAD;
        n = 0;
        while (busy && n < 64) begin
            n++;
            step();
            start = 1'b0;
            hilo_we = HILO_NONE;
        end
        check("busy-ignore cycles", 64'(n), 64'd10);
        e = sb_q.pop_front();
        check("busy-ignore hilo", {hi, lo}, e);

        // Cancel on the third busy cycle of a mult.
        do_write(HILO_MTHI, 32'h11);
        do_write(HILO_MTLO, 32'h22);
        op = MD_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("cancel pre busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel busy drop", 64'(busy), 64'd0);
        repeat (6) step();
        check("cancel hilo kept", {hi, lo}, 64'h00000011_00000022);

        // Cancel together with start: nothing launches.
        cancel = 1'b1; start = 1'b1;
        step();
        cancel = 1'b0; start = 1'b0;
        check("cancel+start busy", 64'(busy), 64'd0);
        repeat (6) step();
        check("cancel+start hilo", {hi, lo}, 64'h00000011_00000022);

        // Start and mthi on the same edge: start wins.
        op = MD_MULT; a = 32'd2; b = 32'd3; start = 1'b1;
        hilo_we = HILO_MTHI; wdata = 32'hFFFF;
        #1;
        check("stall_req on start", 64'(stall_req), 64'd1);
        sb_q.push_back(64'h00000000_00000006);
        step();
        start = 1'b0; hilo_we = HILO_NONE;
        n = 0;
        while (busy && n < 64) begin
            n++;
            step();
        end
        check("start-wins cycles", 64'(n), 64'd5);
        e = sb_q.pop_front();
        check("start-wins hilo", {hi, lo}, e);

        // madd launched the cycle right after commit sees the new hi/lo.
        run_op(MD_MADD, 32'd1, 32'd1, 64'h00000000_00000007, 5, "madd after commit");

        // Reset pulsed mid-div clears everything immediately.
        op = MD_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset hilo", {hi, lo}, 64'd0);
        #3 reset = 1'b1;
        repeat (12) step();
        check("post reset busy", 64'(busy), 64'd0);
        check("post reset no commit", {hi, lo}, 64'd0);

        // One-cycle instance: back-to-back launches each commit after one edge.
        op = MD_MULT; a = 32'd2; b = 32'd3; f_start = 1'b1;
        step();
        f_start = 1'b0;
        check("fast mult busy", 64'(f_busy), 64'd1);
        step();
        check("fast mult done", 64'(f_busy), 64'd0);
        check("fast mult hilo", {f_hi, f_lo}, 64'h00000000_00000006);
        op = MD_DIVU; a = 32'd9; b = 32'd2; f_start = 1'b1;
        step();
        f_start = 1'b0;
        check("fast divu busy", 64'(f_busy), 64'd1);
        step();
        check("fast divu done", 64'(f_busy), 64'd0);
        check("fast divu hilo", {f_hi, f_lo}, 64'h00000001_00000004);
        op = MD_MADD; a = 32'd1; b = 32'd1; f_start = 1'b1;
        step();
        f_start = 1'b0;
        step();
        check("fast madd hilo", {f_hi, f_lo}, 64'h00000001_00000005);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
